sprite_scan_renderer: RTL

- Read-side consumer of the 32x32 palette-indexed sprite frame LUTs.
- Takes the VGA beam position and computes the sprite-local lut_x/lut_y address for the frame LUT bank.
- Registers the returned 3-bit palette index and converts it to RGB222, with index 0 treated as transparent over a background colour.
- Steps the animation frame select on vsync so that successive frames (frame0..frameN) play as a spin loop.

---
 rtl/sprite_scan_renderer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sprite_scan_renderer.sv
// Beam-driven sprite renderer: LUT address generation, palette lookup and frame animation.
// Optional macro SPRITE_PALETTE_WRITE_EN adds a writable palette (pal_we/pal_addr/pal_data).
module sprite_scan_renderer #(
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_HOLD = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       vsync_pulse,
  input  logic [9:0] spr_x,
  input  logic [9:0] spr_y,
  input  logic       anim_en,
  input  logic [5:0] bg_rgb,
  output logic [4:0] lut_x,
  output logic [4:0] lut_y,
  output logic [1:0] frame_sel,
  input  logic [2:0] lut_pixel,
  output logic [5:0] rgb_out,
  output logic       sprite_hit
`ifdef SPRITE_PALETTE_WRITE_EN
  ,
  input  logic       pal_we,
  input  logic [2:0] pal_addr,
  input  logic [5:0] pal_data
`endif
);

  localparam int unsigned SIZE   = 32 << SCALE_LOG2;
  localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  function automatic logic [5:0] default_pal(input logic [2:0] idx);
    case (idx)
      3'd2:    return 6'b111111;
      3'd3:    return 6'b101010;
      3'd4:    return 6'b110110;
      3'd5:    return 6'b010101;
      3'd6:    return 6'b111100;
      3'd7:    return 6'b110000;
      default: return 6'b000000;
    endcase
  endfunction

  // Stage 0: hit test in 11 bits so a sprite near the right/bottom edge clips instead of wrapping
  logic [10:0] hx, vy, sx, sy, dx, dy;
  logic        hit_x, hit_y;

  always_comb begin
    hx    = {1'b0, hpos};
    vy    = {1'b0, vpos};
    sx    = {1'b0, spr_x};
    sy    = {1'b0, spr_y};
    dx    = hx - sx;
    dy    = vy - sy;
    hit_x = (hx >= sx) && (hx < sx + 11'(SIZE));
    hit_y = (vy >= sy) && (vy < sy + 11'(SIZE));
  end

  // Stage 1: texel address plus the flags/background that travel alongside it
  logic       hit_d, don_d;
  logic [5:0] bg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_x <= '0;
      lut_y <= '0;
      hit_d <= 1'b0;
      don_d <= 1'b0;
      bg_d  <= '0;
    end else begin
      hit_d <= hit_x && hit_y;
      don_d <= display_on;
      bg_d  <= bg_rgb;
      if (hit_x && hit_y) begin
        lut_x <= 5'(dx >> SCALE_LOG2);
        lut_y <= 5'(dy >> SCALE_LOG2);
      end else begin
        lut_x <= '0;
        lut_y <= '0;
      end
    end
  end

  logic [5:0] pal_val;

`ifdef SPRITE_PALETTE_WRITE_EN
  logic [5:0] pal_q [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pal_q[i] <= default_pal(3'(i));
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign pal_val = pal_q[lut_pixel];
`else
  assign pal_val = default_pal(lut_pixel);
`endif

  // Stage 2: index 0 is transparent and shows the background
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out    <= '0;
      sprite_hit <= 1'b0;
    end else if (hit_d && don_d && (lut_pixel != 3'd0)) begin
      rgb_out    <= pal_val;
      sprite_hit <= 1'b1;
    end else if (don_d) begin
      rgb_out    <= bg_d;
      sprite_hit <= 1'b0;
    end else begin
      rgb_out    <= '0;
      sprite_hit <= 1'b0;
    end
  end

  // Animation: frame advances only on vsync, so a frame never changes mid-scan
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      frame_sel <= '0;
    end else if (vsync_pulse && anim_en) begin
      if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_cnt  <= '0;
        frame_sel <= (frame_sel == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame_sel + 2'd1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule
